jk_seq_ctrl: RTL and testbench
==============================

JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001: Parameter W, default 4, width of the controlled JK flip-flop bank.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: cmd_valid  input  1  command request.
REQ-005: cmd_ready  output  1  command accepted on a cycle where cmd_valid=1 and cmd_ready=1.
REQ-006: cmd_op  input  2  opcode: 00 count up, 01 count down, 10 load, 11 clear.
REQ-007: cmd_data  input  W  step count for 00/01; target value for 10; ignored for 11.
REQ-008: j  output  W  J excitation to the bank, registered.
REQ-009: k  output  W  K excitation to the bank, registered.
REQ-010: q_fb  input  W  bank outputs fed back; the bank updates on the rising clk edge.
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: done  output  1  one-cycle pulse at command completion.
REQ-013: err  output  1  sticky mismatch flag; cleared on the next command acceptance.

Function
REQ-014: The FSM SHALL have the states IDLE, DRIVE, CHECK and DONE.
REQ-015: cmd_ready SHALL be 1 only in IDLE; in every other state cmd_valid SHALL be ignored (no queuing).
REQ-016: On acceptance, the block SHALL latch op and data, clear err and load a step counter: cmd_data for 00/01, 1 for 10/11.
REQ-017: An accepted 00/01 command with cmd_data=0 SHALL go IDLE->DONE with no drive cycle.
REQ-018: Any other accepted command SHALL go IDLE->DRIVE.
REQ-019: On the edge entering DRIVE, the block SHALL sample q_fb as cur and register nxt: 00 cur+1, 01 cur-1, 10 latched data, 11 zero.
REQ-020: nxt arithmetic SHALL be modulo 2^W (1111+1=0000, 0000-1=1111).
REQ-021: In DRIVE, j SHALL equal ~cur & nxt and k SHALL equal cur & ~nxt (minimal excitation; no toggle codes).
REQ-022: DRIVE SHALL last exactly one cycle, then go to CHECK; the bank captures on that edge.
REQ-023: In CHECK, j and k SHALL be 0 (bank holds).
REQ-024: At the end of CHECK, the block SHALL compare q_fb with nxt.
REQ-025: On a CHECK mismatch, err SHALL be set to 1, the remaining steps abandoned, and the FSM SHALL go to DONE.
REQ-026: On a CHECK match, the step counter SHALL decrement; the FSM SHALL go to DONE if it reaches 0, else to DRIVE.
REQ-027: Each step SHALL take 2 cycles; an N-step command SHALL take 2N+1 cycles from acceptance to done (cycles spent in DRIVE, CHECK and DONE).
REQ-028: DONE SHALL last one cycle with done=1 and j=k=0, then go to IDLE.
REQ-029: j and k SHALL be 0 in IDLE and DONE.
REQ-030: err SHALL hold its value through IDLE until the next acceptance.

Reset
REQ-031: With rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, j=0, k=0, busy=0, done=0, err=0, step counter 0.
REQ-032: A reset asserted mid-command SHALL abort it without a done pulse; the bank retains its last captured value.
REQ-033: After rst_n deasserts, cmd_ready SHALL be 1 on the first rising edge.

Verification
REQ-034: The bench SHALL connect four jk_ff instances (W=4) in closed loop and cover the scenarios below.
REQ-035: Bank at 0000, op 11 -> j=k=0000 in DRIVE, q stays 0000, done after 3 cycles, err=0.
REQ-036: Bank 0000, op 10 data 1010 -> one DRIVE with j=1010 and k=0000, then q=1010, done, err=0.
REQ-037: Bank 1110, op 00 data 3 -> q sequence 1111, 0000, 0001 (wrap), done on cycle 7 after acceptance, busy high throughout.
REQ-038: Bank 0001, op 01 data 2 -> q sequence 0000, 1111; op 00 data 0 -> done on the next cycle with j=k=0 throughout.
REQ-039: Force q_fb bit0 stuck at 0, op 00 data 3 from 0000 -> err=1 after the first CHECK, done pulses, and err clears on the next acceptance.
REQ-040: rst_n low during the second DRIVE of a 3-step count -> j=k=0 and busy=0 immediately, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/jk_seq_ctrl_if.sv
// Command channel for jk_seq_ctrl: valid/ready handshake with opcode and data.
interface jk_seq_ctrl_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/jk_seq_ctrl.sv
// Sequencer driving a W-bit JK flip-flop bank step by step with read-back check.
module jk_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    jk_seq_ctrl_if.slave cmd,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    input  logic [W-1:0] q_fb,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [1:0]   state;
    logic [1:0]   op_r;
    logic [W-1:0] data_r;
    logic [W-1:0] nxt;
    logic [W-1:0] cnt;

    logic         accept;
    logic         zero_step;
    logic [1:0]   op_sel;
    logic [W-1:0] data_sel;
    logic [W-1:0] nxt_c;
    logic [W-1:0] j_c;
    logic [W-1:0] k_c;

    function automatic logic [W-1:0] next_val(
        input logic [1:0]   op,
        input logic [W-1:0] d,
        input logic [W-1:0] cur
    );
        logic [W-1:0] r;
        r = '0;
        unique case (1'b1)
            (op == OP_UP):   r = cur + W'(1);
            (op == OP_DOWN): r = cur - W'(1);
            (op == OP_LOAD): r = d;
            (op == OP_CLR):  r = '0;
        endcase
        return r;
    endfunction

    assign cmd.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    assign accept    = cmd.cmd_valid & cmd.cmd_ready;
    assign zero_step = ~cmd.cmd_op[1] & (cmd.cmd_data == '0);

    // The first step is planned on the accepting edge, before op/data are latched.
    assign op_sel   = (state == S_IDLE) ? cmd.cmd_op   : op_r;
    assign data_sel = (state == S_IDLE) ? cmd.cmd_data : data_r;

    always_comb begin
        nxt_c = next_val(op_sel, data_sel, q_fb);
        j_c   = ~q_fb & nxt_c;
        k_c   = q_fb & ~nxt_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= '0;
            data_r <= '0;
            nxt    <= '0;
            cnt    <= '0;
            j      <= '0;
            k      <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    j <= '0;
                    k <= '0;
                    if (accept) begin
                        op_r   <= cmd.cmd_op;
                        data_r <= cmd.cmd_data;
                        err    <= 1'b0;
                        cnt    <= cmd.cmd_op[1] ? W'(1) : cmd.cmd_data;
                        if (zero_step) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_DRIVE;
                            nxt   <= nxt_c;
                            j     <= j_c;
                            k     <= k_c;
                        end
                    end
                end
                S_DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (q_fb != nxt) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else if (cnt == W'(1)) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt - W'(1);
                        nxt   <= nxt_c;
                        j     <= j_c;
                        k     <= k_c;
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Closed-loop bench: jk_seq_ctrl driving a 4-bit JK bank, scoreboard-checked.
module tb_jk_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] j, k, q_fb, bank, ld_val;
    logic         busy, done, err;
    logic         ld = 1'b0;
    logic         stuck = 1'b0;
    logic         bq [W];

    always #5 clk = ~clk;

    jk_seq_ctrl_if #(.W(W)) cmd ();

    jk_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd.slave),
        .j     (j),
        .k     (k),
        .q_fb  (q_fb),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    for (genvar b = 0; b < W; b++) begin : g_jk_ff
        always @(posedge clk) begin
            if (ld) bq[b] <= ld_val[b];
            else begin
                case ({j[b], k[b]})
                    2'b01:   bq[b] <= 1'b0;
                    2'b10:   bq[b] <= 1'b1;
                    2'b11:   bq[b] <= ~bq[b];
                    default: bq[b] <= bq[b];
                endcase
            end
        end
        assign bank[b] = bq[b];
    end

    logic [W-1:0] stuck_mask;
    assign stuck_mask = {{(W-1){1'b0}}, stuck};
    assign q_fb = bank & ~stuck_mask;

    typedef struct {
        int           cyc;
        logic [W-1:0] q;
        logic         err;
        logic [W-1:0] j1;
        logic [W-1:0] k1;
    } exp_t;

    exp_t         eq [$];
    logic [W-1:0] qq [$];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: follows each accepted command and checks against the queues.
    int           cyc = 0;
    bit           active = 0;
    logic [W-1:0] j1, k1;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
        end else begin
            if (active) begin
                cyc++;
                if (cyc == 1) begin
                    j1 = j;
                    k1 = k;
                end
                chk("busy_hold", busy, 1);
                if (done) begin
                    if (eq.size() == 0) begin
                        errors++;
                        $display("FAIL exp_empty got done at cycle %0d want no done", cyc);
                    end else begin
                        exp_t e;
                        e = eq.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("done_q", bank, e.q);
                        chk("done_err", err, e.err);
                        chk("drive_j", j1, e.j1);
                        chk("drive_k", k1, e.k1);
                        chk("done_jk", {j, k}, 0);
                    end
                    active = 0;
                end else if (cyc % 2 == 0) begin
                    chk("check_jk", {j, k}, 0);
                    if (qq.size() == 0) begin
                        errors++;
                        $display("FAIL qseq_empty got q %0h want no check", bank);
                    end else begin
                        chk("check_q", bank, qq.pop_front());
                    end
                end
                if (active && cyc > 40) begin
                    errors++;
                    $display("FAIL timeout got cycle %0d want done", cyc);
                    active = 0;
                end
            end
            if (cmd.cmd_valid && cmd.cmd_ready) begin
                active = 1;
                cyc    = 0;
                j1     = '0;
                k1     = '0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_data  = d;
        @(posedge clk);
        #1;
        cmd.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL idle_wait got busy %0b want 0", busy);
        end
    endtask

    task automatic preload(input logic [W-1:0] v);
        @(posedge clk);
        #1;
        ld     = 1'b1;
        ld_val = v;
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    function automatic exp_t mk(int c, logic [W-1:0] q, logic e, logic [W-1:0] jj, logic [W-1:0] kk);
        exp_t x;
        x.cyc = c;
        x.q   = q;
        x.err = e;
        x.j1  = jj;
        x.k1  = kk;
        return x;
    endfunction

    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_data  = '0;
        ld_val        = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_jk", {j, k}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", cmd.cmd_ready, 1);

        // clear from 0000
        preload(4'b0000);
        qq.push_back(4'b0000);
        eq.push_back(mk(3, 4'b0000, 0, 4'b0000, 4'b0000));
        issue(2'b11, 4'b0000);
        wait_idle();

        // load 1010 from 0000
        qq.push_back(4'b1010);
        eq.push_back(mk(3, 4'b1010, 0, 4'b1010, 4'b0000));
        issue(2'b10, 4'b1010);
        wait_idle();

        // count up 3 from 1110, wrapping through 0000
        preload(4'b1110);
        qq.push_back(4'b1111);
        qq.push_back(4'b0000);
        qq.push_back(4'b0001);
        eq.push_back(mk(7, 4'b0001, 0, 4'b0001, 4'b0000));
        issue(2'b00, 4'd3);
        wait_idle();

        // count down 2 from 0001, wrapping to 1111
        preload(4'b0001);
        qq.push_back(4'b0000);
        qq.push_back(4'b1111);
        eq.push_back(mk(5, 4'b1111, 0, 4'b0000, 4'b0001));
        issue(2'b01, 4'd2);
        wait_idle();

        // zero-step count goes straight to done
        eq.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b0000));
        issue(2'b00, 4'd0);
        wait_idle();

        // stuck feedback bit: mismatch after first check
        preload(4'b0000);
        stuck = 1'b1;
        qq.push_back(4'b0001);
        eq.push_back(mk(3, 4'b0001, 1, 4'b0001, 4'b0000));
        issue(2'b00, 4'd3);
        wait_idle();
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        qq.push_back(4'b0000);
        eq.push_back(mk(3, 4'b0000, 0, 4'b0000, 4'b0001));
        issue(2'b11, 4'b0000);
        chk("err_clear", err, 0);
        wait_idle();

        // reset during second drive of a 3-step count
        preload(4'b0011);
        qq.push_back(4'b0100);
        issue(2'b00, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_drive_j", j, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("abort_jk", {j, k}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", cmd.cmd_ready, 1);
        chk("abort_bank", bank, 4'b0100);

        repeat (3) @(posedge clk);
        chk("exp_drained", eq.size(), 0);
        chk("qseq_drained", qq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
